uart_fifo_regs: RTL and testbench

Parametrised memory-mapped register block for the UART, sitting between the CPU data bus and the UART RX/TX engines. It adds a configurable-depth RX FIFO and TX FIFO, a TX dispatch state machine, sticky overrun flags and a level interrupt. Bit rate and stop-bit configuration registers are kept.

---
 rtl/uart_fifo_regs.sv | 200 ++++++++++++++++++++
 tb/tb_uart_fifo_regs.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_regs.sv
// UART register block: CPU-facing config/status registers, RX and TX byte FIFOs,
// a TX dispatch FSM feeding the TX engine, sticky overrun flags and a level irq.
module uart_fifo_regs #(
  parameter int          RX_DEPTH = 16,
  parameter int          TX_DEPTH = 16,
  parameter logic [15:0] CBP_RST  = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        write_bus,
  input  logic        read_bus,
  input  logic [3:0]  be_bus,
  input  logic [31:0] addr_bus,
  input  logic [31:0] data_i_bus,
  output logic [31:0] data_o_bus,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_done_i,
  input  logic        tx_done_i,
  output logic [15:0] cbp_o,
  output logic [1:0]  stop_bits_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        irq_o
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_CW = TX_AW + 1;
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} tx_state_e;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [15:0]      cbp_q, cbp_d;
  logic [1:0]       stop_q, stop_d;
  logic             en_q, en_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
  logic             rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic             irq_q, irq_d;
  logic [7:0]       tx_data_q, tx_data_d;
  tx_state_e        state_q, state_d;

  logic [2:0] word_s;
  logic       in_range_s, reg_wr_s, cfg_wr_s;
  logic       rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_ovf_evt_s;
  logic       tx_empty_s, tx_full_s, tx_wr_s, tx_push_s, tx_ovf_evt_s, tx_start_s;
  logic       unused_s;

  assign unused_s = ^{addr_bus[1:0], be_bus[3:2], data_i_bus[31:16]};

  // Address decode, FIFO handshakes and TX dispatch decision
  always_comb begin
    word_s       = addr_bus[4:2];
    in_range_s   = (addr_bus[31:5] == 27'd0);
    reg_wr_s     = write_bus & in_range_s;
    cfg_wr_s     = reg_wr_s & (word_s == 3'd4) & be_bus[0];
    rx_empty_s   = (rx_cnt_q == RX_CW'(0));
    rx_full_s    = (rx_cnt_q == RX_FULL_CNT);
    tx_empty_s   = (tx_cnt_q == TX_CW'(0));
    tx_full_s    = (tx_cnt_q == TX_FULL_CNT);
    rx_pop_s     = read_bus & in_range_s & (word_s == 3'd2) & ~rx_empty_s;
    // A full RX FIFO still accepts a byte when the CPU pops in the same cycle
    rx_push_s    = rx_done_i & (~rx_full_s | rx_pop_s);
    rx_ovf_evt_s = rx_done_i & rx_full_s & ~rx_pop_s;
    tx_wr_s      = reg_wr_s & (word_s == 3'd3) & be_bus[0];
    tx_push_s    = tx_wr_s & ~tx_full_s;
    tx_ovf_evt_s = tx_wr_s & tx_full_s;
    tx_start_s   = (state_q == ST_IDLE) & en_q & ~tx_empty_s;
  end

  assign tx_start_o  = tx_start_s;
  assign tx_data_o   = tx_start_s ? tx_mem_q[tx_rptr_q] : tx_data_q;
  assign cbp_o       = cbp_q;
  assign stop_bits_o = stop_q;
  assign irq_o       = irq_q;

  // Next-state for registers, FIFO bookkeeping and the TX FSM
  always_comb begin
    cbp_d     = cbp_q;
    stop_d    = stop_q;
    en_d      = en_q;
    rx_ie_d   = rx_ie_q;
    tx_ie_d   = tx_ie_q;
    state_d   = state_q;
    tx_data_d = tx_data_o;

    if (reg_wr_s && (word_s == 3'd0)) begin
      cbp_d[7:0]  = be_bus[0] ? data_i_bus[7:0]  : cbp_q[7:0];
      cbp_d[15:8] = be_bus[1] ? data_i_bus[15:8] : cbp_q[15:8];
    end else begin
      cbp_d = cbp_q;
    end

    if (reg_wr_s && (word_s == 3'd1) && be_bus[0]) begin
      stop_d = data_i_bus[1:0];
    end else begin
      stop_d = stop_q;
    end

    if (cfg_wr_s) begin
      en_d    = data_i_bus[0];
      rx_ie_d = data_i_bus[1];
      tx_ie_d = data_i_bus[2];
    end else begin
      en_d    = en_q;
      rx_ie_d = rx_ie_q;
      tx_ie_d = tx_ie_q;
    end

    // New overrun events win over a simultaneous write-1-to-clear
    rx_ovf_d = rx_ovf_evt_s | (rx_ovf_q & ~(cfg_wr_s & data_i_bus[3]));
    tx_ovf_d = tx_ovf_evt_s | (tx_ovf_q & ~(cfg_wr_s & data_i_bus[4]));

    rx_wptr_d = rx_push_s ? rx_wptr_q + RX_AW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop_s  ? rx_rptr_q + RX_AW'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q + RX_CW'(rx_push_s) - RX_CW'(rx_pop_s);
    tx_wptr_d = tx_push_s  ? tx_wptr_q + TX_AW'(1) : tx_wptr_q;
    tx_rptr_d = tx_start_s ? tx_rptr_q + TX_AW'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q + TX_CW'(tx_push_s) - TX_CW'(tx_start_s);

    case (state_q)
      ST_IDLE: state_d = tx_start_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_d = tx_done_i ? ST_IDLE : ST_BUSY;
      default: state_d = ST_IDLE;
    endcase

    irq_d = (rx_ie_q & ~rx_empty_s) | (tx_ie_q & tx_empty_s & (state_q == ST_IDLE))
          | rx_ovf_q | tx_ovf_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cbp_q     <= CBP_RST;
      stop_q    <= 2'd0;
      en_q      <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      irq_q     <= 1'b0;
      tx_data_q <= 8'd0;
      state_q   <= ST_IDLE;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      cbp_q     <= cbp_d;
      stop_q    <= stop_d;
      en_q      <= en_d;
      rx_ie_q   <= rx_ie_d;
      tx_ie_q   <= tx_ie_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
      irq_q     <= irq_d;
      tx_data_q <= tx_data_d;
      state_q   <= state_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until counted in
  always_ff @(posedge clk_i) begin
    if (rx_push_s) rx_mem_q[rx_wptr_q] <= rx_data_i;
    if (tx_push_s) tx_mem_q[tx_wptr_q] <= data_i_bus[7:0];
  end

  // Combinational read mux
  always_comb begin
    data_o_bus = 32'd0;
    if (in_range_s) begin
      case (word_s)
        3'd0:    data_o_bus = {16'd0, cbp_q};
        3'd1:    data_o_bus = {30'd0, stop_q};
        3'd2:    data_o_bus = rx_empty_s ? 32'd0 : {24'd0, rx_mem_q[rx_rptr_q]};
        3'd4:    data_o_bus = {20'd0, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, 3'd0,
                               tx_ovf_q, rx_ovf_q, tx_ie_q, rx_ie_q, en_q};
        3'd5:    data_o_bus = {{(16-TX_CW){1'b0}}, tx_cnt_q, {(16-RX_CW){1'b0}}, rx_cnt_q};
        default: data_o_bus = 32'd0;
      endcase
    end else begin
      data_o_bus = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_regs.sv
// Scoreboard bench for uart_fifo_regs: a queue-based reference model predicts reads and
// transmitted bytes; independent monitors compare whenever the DUT presents them.
module tb_uart_fifo_regs;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        write_bus = 1'b0, read_bus = 1'b0;
  logic [3:0]  be_bus = 4'd0;
  logic [31:0] addr_bus = 32'd0, data_i_bus = 32'd0;
  logic [31:0] data_o_bus;
  logic [7:0]  rx_data_i = 8'd0;
  logic        rx_done_i = 1'b0, tx_done_i = 1'b0;
  logic [15:0] cbp_o;
  logic [1:0]  stop_bits_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o, irq_o;

  always #5 clk = ~clk;

  uart_fifo_regs #(.RX_DEPTH(DEP), .TX_DEPTH(DEP), .CBP_RST(16'd868)) dut (
    .clk_i(clk), .rst_i(rst_i), .write_bus(write_bus), .read_bus(read_bus),
    .be_bus(be_bus), .addr_bus(addr_bus), .data_i_bus(data_i_bus), .data_o_bus(data_o_bus),
    .rx_data_i(rx_data_i), .rx_done_i(rx_done_i), .tx_done_i(tx_done_i),
    .cbp_o(cbp_o), .stop_bits_o(stop_bits_o), .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o), .irq_o(irq_o));

  int checks = 0;
  int errors = 0;
  int starts = 0;

  // reference model state
  logic [15:0] m_cbp;
  logic [1:0]  m_stop;
  bit          m_en, m_rxie, m_txie, m_rxovf, m_txovf;
  logic [7:0]  m_rxq[$];
  logic [7:0]  m_txq[$];
  logic [31:0] rd_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cbp = 16'd868; m_stop = 2'd0;
    m_en = 1'b0; m_rxie = 1'b0; m_txie = 1'b0; m_rxovf = 1'b0; m_txovf = 1'b0;
    m_rxq.delete(); m_txq.delete();
  endtask

  function automatic logic [31:0] m_status();
    return {20'd0, m_txq.size() == DEP, m_txq.size() == 0, m_rxq.size() == DEP,
            m_rxq.size() == 0, 3'd0, m_txovf, m_rxovf, m_txie, m_rxie, m_en};
  endfunction

  // One bus/RX cycle: model predicts at issue time, then the DUT sees it on the next edge
  task automatic do_cycle(input bit wr, input bit rd, input bit rxv, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input logic [7:0] rxd);
    logic [2:0]  w;
    logic [31:0] e;
    bit inr, rx_full, rx_pop, rx_evt, tx_wr, tx_evt, cfg_wr;
    w = addr[4:2];
    inr = (addr[31:5] == 27'd0);
    if (rd) begin
      e = 32'd0;
      if (inr) begin
        case (w)
          3'd0: e = {16'd0, m_cbp};
          3'd1: e = {30'd0, m_stop};
          3'd2: e = (m_rxq.size() > 0) ? {24'd0, m_rxq[0]} : 32'd0;
          3'd4: e = m_status();
          3'd5: e = {16'(m_txq.size()), 16'(m_rxq.size())};
          default: e = 32'd0;
        endcase
      end
      rd_exp.push_back(e);
    end
    rx_full = (m_rxq.size() == DEP);
    rx_pop = rd && inr && (w == 3'd2) && (m_rxq.size() > 0);
    if (rx_pop) void'(m_rxq.pop_front());
    rx_evt = rxv && rx_full && !rx_pop;
    if (rxv && !rx_evt) m_rxq.push_back(rxd);
    tx_wr = wr && inr && (w == 3'd3) && be[0];
    tx_evt = tx_wr && (m_txq.size() == DEP);
    if (tx_wr && !tx_evt) m_txq.push_back(data[7:0]);
    cfg_wr = wr && inr && (w == 3'd4) && be[0];
    if (wr && inr && w == 3'd0 && be[0]) m_cbp[7:0] = data[7:0];
    if (wr && inr && w == 3'd0 && be[1]) m_cbp[15:8] = data[15:8];
    if (wr && inr && w == 3'd1 && be[0]) m_stop = data[1:0];
    if (cfg_wr) begin
      m_en = data[0]; m_rxie = data[1]; m_txie = data[2];
    end
    m_rxovf = rx_evt || (m_rxovf && !(cfg_wr && data[3]));
    m_txovf = tx_evt || (m_txovf && !(cfg_wr && data[4]));
    write_bus = wr; read_bus = rd; rx_done_i = rxv;
    addr_bus = addr; data_i_bus = data; be_bus = be; rx_data_i = rxd;
    sync();
    write_bus = 1'b0; read_bus = 1'b0; rx_done_i = 1'b0;
  endtask

  task automatic wr(input int word, input logic [31:0] data, input logic [3:0] be);
    do_cycle(1'b1, 1'b0, 1'b0, 32'(word) << 2, data, be, 8'd0);
  endtask

  task automatic rd(input int word);
    do_cycle(1'b0, 1'b1, 1'b0, 32'(word) << 2, 32'd0, 4'd0, 8'd0);
  endtask

  task automatic rx(input logic [7:0] b);
    do_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, b);
  endtask

  task automatic wait_start(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      @(negedge clk);
      seen = tx_start_o;
    end
    check(nm, {31'd0, seen}, 32'd1);
    sync();
  endtask

  task automatic pulse_done(input int wait_cycles);
    repeat (wait_cycles) sync();
    tx_done_i = 1'b1;
    sync();
    tx_done_i = 1'b0;
  endtask

  task automatic peek(input string nm, input logic [31:0] act, input logic [31:0] req);
    check(nm, act, req);
  endtask

  // read monitor: every DUT read cycle is matched against the oldest prediction
  always @(negedge clk) begin
    if (read_bus) begin
      if (rd_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected actual=%h required=none", data_o_bus);
      end else begin
        check("read", data_o_bus, rd_exp.pop_front());
      end
    end
  end

  // TX monitor: every start pulse must carry the oldest byte accepted into the TX FIFO
  always @(negedge clk) begin
    if (!rst_i && tx_start_o) begin
      starts++;
      if (m_txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_start_unexpected actual=%h required=none", tx_data_o);
      end else begin
        check("tx_data", {24'd0, tx_data_o}, {24'd0, m_txq.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] a, d;
    model_reset();
    repeat (3) sync();
    rst_i = 1'b0;
    @(negedge clk);
    peek("rst_cbp", {16'd0, cbp_o}, 32'd868);
    peek("rst_stop", {30'd0, stop_bits_o}, 32'd0);
    peek("rst_txdata", {24'd0, tx_data_o}, 32'd0);
    peek("rst_txstart", {31'd0, tx_start_o}, 32'd0);
    peek("rst_irq", {31'd0, irq_o}, 32'd0);
    sync();

    // register access
    rd(0);
    wr(1, 32'd3, 4'b0001);
    rd(1);
    wr(0, 32'h1234_5678, 4'b0010);
    rd(0);
    @(negedge clk);
    peek("cbp_byte1", {16'd0, cbp_o}, 32'h0000_5664);
    peek("stop_out", {30'd0, stop_bits_o}, 32'd3);
    sync();

    // RX fill past full
    for (int i = 0; i < 5; i++) rx(8'hA1 + 8'(i));
    rd(4);
    rd(5);
    for (int i = 0; i < 5; i++) rd(2);
    wr(4, 32'h0000_0008, 4'b0001);

    // RX push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) rx(8'hB1 + 8'(i));
    do_cycle(1'b0, 1'b1, 1'b1, 32'd8, 32'd0, 4'd0, 8'hB5);
    rd(5);
    rd(4);
    for (int i = 0; i < 4; i++) rd(2);

    // TX ordering and start latency
    base = starts;
    wr(4, 32'd1, 4'b0001);
    wr(3, 32'h55, 4'b0001);
    wait_start(1, "start_latency");
    wr(3, 32'h66, 4'b0001);
    pulse_done(7);
    @(negedge clk);
    peek("start_after_done", {31'd0, tx_start_o}, 32'd1);
    sync();
    pulse_done(9);
    repeat (5) sync();
    check("two_starts", 32'(starts - base), 32'd2);
    rd(4);

    // TX overflow with dispatch disabled, then enable
    wr(4, 32'd0, 4'b0001);
    for (int i = 0; i < 5; i++) wr(3, 32'hC1 + 32'(i), 4'b0001);
    rd(4);
    rd(5);
    wr(4, 32'h10, 4'b0001);
    rd(4);
    base = starts;
    wr(4, 32'd1, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      wait_start(5, "drain_start");
      pulse_done(2);
    end
    repeat (4) sync();
    check("four_starts", 32'(starts - base), 32'd4);
    rd(4);

    // interrupt timing on RX data
    wr(4, 32'd2, 4'b0001);
    repeat (2) sync();
    rx(8'h3C);
    @(negedge clk); peek("irq_lag_lo", {31'd0, irq_o}, 32'd0); sync();
    @(negedge clk); peek("irq_rise", {31'd0, irq_o}, 32'd1); sync();
    rd(2);
    @(negedge clk); peek("irq_lag_hi", {31'd0, irq_o}, 32'd1); sync();
    @(negedge clk); peek("irq_fall", {31'd0, irq_o}, 32'd0); sync();

    // reset while BUSY
    wr(4, 32'd1, 4'b0001);
    wr(3, 32'hD1, 4'b0001);
    wait_start(2, "busy_start");
    wr(3, 32'hD2, 4'b0001);
    rx(8'hE7);
    repeat (3) sync();
    rst_i = 1'b1;
    sync();
    rst_i = 1'b0;
    model_reset();
    base = starts;
    @(negedge clk);
    peek("rst2_txdata", {24'd0, tx_data_o}, 32'd0);
    peek("rst2_irq", {31'd0, irq_o}, 32'd0);
    sync();
    rd(4);
    rd(5);
    rd(0);
    wr(4, 32'd1, 4'b0001);
    repeat (10) sync();
    check("no_start_after_reset", 32'(starts - base), 32'd0);
    wr(4, 32'd0, 4'b0001);

    // randomized traffic with dispatch disabled
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0: wr($urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)));
        1: rd($urandom_range(0, 7));
        2: do_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 32'd8, 32'd0, 4'd0, 8'($urandom));
        3: wr(3, $urandom, 4'($urandom_range(0, 15)));
        4: begin
          a = (32'h20 << $urandom_range(0, 26)) | (32'($urandom_range(0, 7)) << 2);
          d = $urandom;
          do_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, a, d, 4'hF, 8'd0);
        end
        default: wr(4, 32'($urandom_range(0, 3)) << 3, 4'b0001);
      endcase
    end
    @(negedge clk);
    peek("rand_cbp", {16'd0, cbp_o}, {16'd0, m_cbp});
    peek("rand_stop", {30'd0, stop_bits_o}, {30'd0, m_stop});
    sync();
    rd(4);
    rd(5);
    for (int i = 0; i < DEP + 1; i++) rd(2);
    repeat (2) sync();
    check("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
